// File: rtl/btn_evt_ctrl.sv
// -----------------------------------------------------------------------------
// btn_evt_ctrl
//   Front-panel button event controller. Produces the shared debounce sample
//   tick, detects rising edges on the debounced button levels, keeps one
//   pending press per button, and hands pending presses to the main FSM one at
//   a time through a valid/ready port with round-robin arbitration. A single
//   shared hold timer adds long-press auto-repeat events for the most recently
//   pressed button.
//
// Ports
//   clk          in   1              rising-edge clock
//   rst          in   1              synchronous reset, active low
//   i_btn        in   N_BTN          debounced button levels, 1 = pressed
//   o_tick       out  1              one-cycle debounce sample strobe
//   o_evt_valid  out  1              event available
//   o_evt_id     out  $clog2(N_BTN)  button index of the event
//   o_evt_long   out  1              0 = press, 1 = auto-repeat
//   i_evt_ready  in   1              consumer takes the event on valid & ready
// -----------------------------------------------------------------------------
module btn_evt_ctrl #(
    parameter int N_BTN     = 4,
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_BTN-1:0]           i_btn,
    output logic                       o_tick,
    output logic                       o_evt_valid,
    output logic [$clog2(N_BTN)-1:0]   o_evt_id,
    output logic                       o_evt_long,
    input  logic                       i_evt_ready
);

    localparam int ID_W  = $clog2(N_BTN);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int T_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int TMR_W = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REPEAT} hold_state_t;

    // Hold timer increments but pins at its largest value instead of wrapping.
    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        if (v >= TMR_W'(T_MAX))
            return v;
        else
            return v + TMR_W'(1);
    endfunction

    logic [CNT_W-1:0] tick_cnt;
    logic [N_BTN-1:0] btn_d;
    logic [N_BTN-1:0] rise;
    logic             rise_any;
    logic [ID_W-1:0]  rise_id;
    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] pend_long;
    logic [N_BTN-1:0] pend_n;
    logic [N_BTN-1:0] pend_long_n;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  cand;
    int               idx;
    logic             grant_vld;
    logic             slot_free;
    logic             load;
    hold_state_t      state;
    logic [ID_W-1:0]  hold_id;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_inc;
    logic [TMR_W-1:0] thr;
    logic             held;
    logic             post;
    logic             post_ok;

    // Stage: edge detect; lowest rising index claims the hold timer
    always_comb begin
        rise     = i_btn & ~btn_d;
        rise_any = |rise;
        rise_id  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (rise[i])
                rise_id = ID_W'(i);
        end
    end

    // Stage: round-robin grant, searching upward from the last winner
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        idx       = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx  = (int'(last_grant) + k) % N_BTN;
            cand = ID_W'(idx);
            if (!grant_vld && pend[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
        slot_free = !o_evt_valid || i_evt_ready;
        load      = slot_free && grant_vld;
    end

    // Stage: repeat decision; a fresh press always restarts the timer instead
    always_comb begin
        timer_inc = sat_inc(timer);
        thr       = (state == S_ARMED) ? TMR_W'(LONG_MS) : TMR_W'(REPEAT_MS);
        held      = i_btn[hold_id];
        post      = !rise_any && (state != S_IDLE) && held && o_tick
                    && (timer_inc >= thr);
        // A repeat never stacks on an event that is still waiting.
        post_ok   = post && !pend[hold_id];
    end

    // Stage: pending set update; a new rise wins over the grant clearing it
    always_comb begin
        pend_n      = pend;
        pend_long_n = pend_long;
        if (load)
            pend_n[grant] = 1'b0;
        pend_n      = pend_n | rise;
        pend_long_n = pend_long_n & ~rise;
        if (post_ok) begin
            pend_n[hold_id]      = 1'b1;
            pend_long_n[hold_id] = 1'b1;
        end
    end

    // Stage: registered state and outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt    <= '0;
            o_tick      <= 1'b0;
            btn_d       <= i_btn;
            pend        <= '0;
            pend_long   <= '0;
            o_evt_valid <= 1'b0;
            o_evt_id    <= '0;
            o_evt_long  <= 1'b0;
            last_grant  <= ID_W'(N_BTN - 1);
            state       <= S_IDLE;
            hold_id     <= '0;
            timer       <= '0;
        end else begin
            if (tick_cnt == CNT_W'(DIV - 1)) begin
                tick_cnt <= '0;
                o_tick   <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
                o_tick   <= 1'b0;
            end

            btn_d     <= i_btn;
            pend      <= pend_n;
            pend_long <= pend_long_n;

            if (slot_free) begin
                if (grant_vld) begin
                    o_evt_valid <= 1'b1;
                    o_evt_id    <= grant;
                    o_evt_long  <= pend_long[grant];
                    last_grant  <= grant;
                end else begin
                    o_evt_valid <= 1'b0;
                end
            end

            if (rise_any) begin
                state   <= S_ARMED;
                hold_id <= rise_id;
                timer   <= '0;
            end else begin
                case (state)
                    S_ARMED, S_REPEAT: begin
                        if (!held) begin
                            state <= S_IDLE;
                            timer <= '0;
                        end else if (o_tick) begin
                            if (timer_inc >= thr) begin
                                state <= S_REPEAT;
                                timer <= '0;
                            end else begin
                                timer <= timer_inc;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
